// File: rtl/lcu_datapath.sv
// lcu_datapath: strobe-driven datapath returning condition flags to the logic control unit
module lcu_datapath #(
  parameter int W = 8,
  parameter int TIMER_LEN = 4,
  parameter int EVT_MAX = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         y1,
  input  logic         y2,
  input  logic         y3,
  input  logic         y4,
  input  logic         y5,
  input  logic         y6,
  input  logic         y7,
  input  logic         y8,
  input  logic         y9,
  input  logic         y10,
  input  logic         y11,
  input  logic         y12,
  input  logic         y13,
  input  logic         y14,
  input  logic         y15,
  input  logic         y16,
  input  logic         y17,
  input  logic         y18,
  input  logic         y19,
  input  logic         y21,
  input  logic         y22,
  input  logic         y23,
  input  logic         y24,
  input  logic         mode_in,
  input  logic [W-1:0] data_in,
  input  logic         data_valid,
  output logic         data_take,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         x1,
  output logic         x2,
  output logic         x3,
  output logic         x4,
  output logic         x5,
  output logic         x6,
  output logic         x7,
  output logic         x8,
  output logic         x9,
  output logic         x10,
  output logic         x11,
  output logic         x12,
  output logic         x13,
  output logic         x14,
  output logic         x15
);
  logic [W-1:0] a, b, a_n, b_n;
  logic [W:0] sum;
  logic [3:0] t, t_n, c, c_n;
  logic done, ovf, x15r, dvr;
  logic done_n, ovf_n, carry, hs, emit, drop, ov_n;
  logic unused_strobes;

  assign unused_strobes = ^{y13, y15, y16, y18, y19, y21, y22, y23};

  // next state: operand priority chains, timer, sticky flags, emit handshake, event counter
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    carry = y9 & ~y1 & ~y5 & ~y8 & sum[W];
    a_n = y1 ? '0 : y5 ? data_in : y8 ? b : y9 ? sum[W-1:0] : a + W'(y2) - W'(y4);
    b_n = y1 ? '0 : y6 ? data_in : y8 ? a : b + W'(y3) - W'(y14);
    t_n = y7 ? 4'(TIMER_LEN) : (t != 4'd0) ? t - 4'd1 : t;
    done_n = (~y7 & (t == 4'd1)) | (done & ~y10);
    hs = out_valid & out_ready;
    emit = y11 & (~out_valid | hs);
    drop = y11 & out_valid & ~hs;
    ov_n = emit | (out_valid & ~hs);
    ovf_n = carry | drop | (ovf & ~y12);
    c_n = y24 ? 4'd0 : (y17 && (c != 4'(EVT_MAX))) ? c + 4'd1 : c;
  end

  // state register; reset may arrive at any time, even mid-timer or with an emit pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      t <= '0;
      c <= '0;
      done <= 1'b0;
      ovf <= 1'b0;
      x15r <= 1'b0;
      dvr <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      data_take <= 1'b0;
    end else begin
      a <= a_n;
      b <= b_n;
      t <= t_n;
      c <= c_n;
      done <= done_n;
      ovf <= ovf_n;
      x15r <= mode_in;
      dvr <= data_valid;
      out_valid <= ov_n;
      if (emit) out_data <= a;
      data_take <= (y5 | y6) & data_valid;
    end
  end

  assign x1 = (a == '0);
  assign x2 = a[0];
  assign x3 = (a > b);
  assign x4 = (a == b);
  assign x5 = (b == '0);
  assign x6 = b[0];
  assign x7 = (t != 4'd0);
  assign x8 = done;
  assign x9 = a[W-1];
  assign x10 = b[W-1];
  assign x11 = ovf;
  assign x12 = (c == 4'(EVT_MAX));
  assign x13 = dvr;
  assign x14 = out_valid;
  assign x15 = x15r;
endmodule
